mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning data memory address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data word width in bits.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-005 SHALL have ports req_0, req_1  input  1 each  access request from port 0 (core datapath) and port 1 (loader/debug).
REQ-006 SHALL have ports we_0, we_1  input  1 each  write enable; 0 means read.
REQ-007 SHALL have ports addr_0, addr_1  input  ADDR_W each  word address.
REQ-008 SHALL have ports wdata_0, wdata_1  input  DATA_W each  write data.
REQ-009 SHALL have ports gnt_0, gnt_1  output  1 each  request accepted this cycle.
REQ-010 SHALL have ports rvalid_0, rvalid_1  output  1 each  read data valid for that port.
REQ-011 SHALL have port rdata  output  DATA_W  read data, shared by both ports and qualified by rvalid_x.
REQ-012 SHALL have ports mem_req, mem_we  output  1 each  memory access strobe and write enable.
REQ-013 SHALL have ports mem_addr, mem_wdata  output  ADDR_W and DATA_W  memory address and write data.
REQ-014 SHALL have port mem_rdata  input  DATA_W  synchronous memory read data, valid one cycle after a read strobe.

Function
REQ-015 SHALL compute grants combinationally from the current cycle's req_x; at most one of gnt_0 and gnt_1 is high in any cycle.
REQ-016 SHALL drive mem_req=1 together with the granted port's we/addr/wdata in the grant cycle; with no grant: mem_req=0, mem_we=0, mem_addr and mem_wdata=0.
REQ-017 SHALL accept one new access every cycle; back-to-back grants are allowed, with no idle cycle between them.
REQ-018 SHALL, for a granted read, assert rvalid_x of the granted port exactly one cycle after grant, with rdata=mem_rdata; writes produce no rvalid.
REQ-019 SHALL hold one registered response slot (pending flag plus port ID) so that a read response and a new grant can occur in the same cycle.
REQ-020 SHALL drive rdata to 0 when neither rvalid_0 nor rvalid_1 is high.
REQ-021 SHALL require each requester to hold req, we, addr and wdata stable until its gnt; the arbiter does not store requests.
REQ-022 SHALL grant a request from a single requester in the same cycle.
REQ-023 SHALL, for simultaneous requests, apply the arbitration policy of REQ-028/REQ-029.
REQ-024 SHALL keep a 1-bit last_grant register that updates only in cycles where a grant occurs.

Reset
REQ-025 SHALL force gnt_0, gnt_1, mem_req and mem_we to 0 while rst is high, regardless of req_x.
REQ-026 SHALL clear the pending response on reset: a read granted in the cycle before rst was asserted produces no rvalid, and rvalid_0, rvalid_1 and rdata are 0 in the cycle after the rst edge.
REQ-027 SHALL reset last_grant to 1, so that port 0 wins the first contention after reset.

Configuration
REQ-028 SHALL, with MEM_ARB_ROUND_ROBIN_EN defined, resolve contention in favour of the port not equal to last_grant, so the winner alternates under continuous contention.
REQ-029 SHALL, without MEM_ARB_ROUND_ROBIN_EN, resolve contention always in favour of port 0 (fixed priority); last_grant is still kept but has no effect.

Verification
REQ-030 SHALL cover: only req_0 reads addr 0x10 (memory holds 0xDEADBEEF) -> gnt_0 in the same cycle, rvalid_0=1 with rdata=0xDEADBEEF on the next cycle, rvalid_1=0.
REQ-031 SHALL cover: req_0 and req_1 held high for 4 cycles after reset with round-robin -> grant sequence 0,1,0,1; without the macro -> 0,0,0,0 and no gnt_1.
REQ-032 SHALL cover: port 1 writes 0x12345678 to 0x20, then port 0 reads 0x20 in the next cycle -> mem_we=1 then mem_we=0, rvalid_0=1 with rdata=0x12345678, no rvalid_1.
REQ-033 SHALL cover: port 0 read granted in cycle N, rst=1 in cycle N+1 -> no rvalid in cycle N+1 or N+2, and all outputs 0 during reset.
REQ-034 SHALL cover: continuous back-to-back reads alternating ports at addresses 0..7 -> one grant every cycle, each rvalid_x one cycle later on the correct port with matching data.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port data memory arbiter with a single registered read-response slot.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; fixed priority to port 0 otherwise.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_0,
   input  logic              req_1,
   input  logic              we_0,
   input  logic              we_1,
   input  logic [ADDR_W-1:0] addr_0,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [DATA_W-1:0] wdata_0,
   input  logic [DATA_W-1:0] wdata_1,
   output logic              gnt_0,
   output logic              gnt_1,
   output logic              rvalid_0,
   output logic              rvalid_1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   logic last_q, last_d, pend_q, pend_d, pid_q, pid_d, pick_1;
   always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pick_1 = (req_0 & req_1) ? ~last_q : req_1;
`else
      pick_1 = ~req_0 & req_1;
`endif
      gnt_0 = ~rst & req_0 & ~pick_1;
      gnt_1 = ~rst & req_1 & pick_1;
      mem_req = gnt_0 | gnt_1;
      mem_we = gnt_0 ? we_0 : gnt_1 ? we_1 : 1'b0;
      mem_addr = gnt_0 ? addr_0 : gnt_1 ? addr_1 : '0;
      mem_wdata = gnt_0 ? wdata_0 : gnt_1 ? wdata_1 : '0;
      pend_d = mem_req & ~mem_we;
      pid_d = gnt_1;
      last_d = mem_req ? gnt_1 : last_q;
      // Gate with rst so a response pending across the reset edge is never seen.
      rvalid_0 = ~rst & pend_q & ~pid_q;
      rvalid_1 = ~rst & pend_q & pid_q;
      rdata = (rvalid_0 | rvalid_1) ? mem_rdata : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
         pend_q <= 1'b0;
         pid_q  <= 1'b0;
      end else begin
         last_q <= last_d;
         pend_q <= pend_d;
         pid_q  <= pid_d;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a behavioural model.
module tb_mem_arbiter;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, req_0, req_1, we_0, we_1, gnt_0, gnt_1, rvalid_0, rvalid_1, mem_req, mem_we;
   logic [31:0] addr_0, addr_1, wdata_0, wdata_1, rdata, mem_addr, mem_wdata, mem_rdata;
   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
      .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
      .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1), .rdata(rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata));
   function automatic logic [31:0] init_val(int i);
      return (i == 16) ? 32'hDEADBEEF : ((i * 32'h01010101) ^ 32'hA5A50000);
   endfunction
   // Synchronous memory fixture: read data appears one cycle after the strobe.
   logic [31:0] fx [256];
   logic fx_init = 1'b0;
   always @(posedge clk) begin
      if (!fx_init) begin
         for (int i = 0; i < 256; i++) fx[i] <= init_val(i);
         fx_init <= 1'b1;
      end else if (mem_req) begin
         if (mem_we) fx[mem_addr[7:0]] <= mem_wdata;
         else mem_rdata <= fx[mem_addr[7:0]];
      end
   end
   logic [31:0] shadow [256];
   int total = 0, bad = 0;
   int lw = 1, last_win = -1, pport = 0;
   bit pend = 1'b0;
   logic [31:0] pdata = '0;
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      int w;
      logic [7:0] a;
      w = rst ? -1 : (req_0 && req_1) ? (RR ? 1 - lw : 0) : req_0 ? 0 : req_1 ? 1 : -1;
      @(negedge clk);
      chk("gnt_0", gnt_0, w == 0);
      chk("gnt_1", gnt_1, w == 1);
      chk("mem_req", mem_req, w >= 0);
      chk("mem_we", mem_we, w == 0 ? we_0 : w == 1 ? we_1 : 1'b0);
      chk("mem_addr", mem_addr, w == 0 ? addr_0 : w == 1 ? addr_1 : 32'h0);
      chk("mem_wdata", mem_wdata, w == 0 ? wdata_0 : w == 1 ? wdata_1 : 32'h0);
      chk("rvalid_0", rvalid_0, !rst && pend && pport == 0);
      chk("rvalid_1", rvalid_1, !rst && pend && pport == 1);
      chk("rdata", rdata, (!rst && pend) ? pdata : 32'h0);
      pend = 1'b0;
      last_win = w;
      if (rst) lw = 1;
      else if (w >= 0) begin
         lw = w;
         a = (w == 1) ? addr_1[7:0] : addr_0[7:0];
         if ((w == 1) ? we_1 : we_0) shadow[a] = (w == 1) ? wdata_1 : wdata_0;
         else begin
            pend = 1'b1;
            pport = w;
            pdata = shadow[a];
         end
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      int seq [4];
      bit act_0, act_1;
      for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
      rst = 1'b1; req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0;
      addr_0 = 0; addr_1 = 0; wdata_0 = 0; wdata_1 = 0;
      cyc(); cyc();
      rst = 1'b0;
      // single read from port 0
      req_0 = 1; addr_0 = 32'h10;
      cyc();
      req_0 = 0;
      chk("r030_rvalid_0", rvalid_0, 1'b1);
      chk("r030_rvalid_1", rvalid_1, 1'b0);
      chk("r030_rdata", rdata, 32'hDEADBEEF);
      cyc();
      // contention right after reset
      rst = 1'b1; cyc(); rst = 1'b0;
      req_0 = 1; req_1 = 1; addr_0 = 0; addr_1 = 1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         seq[i] = last_win;
      end
      for (int i = 0; i < 4; i++) chk("r031_seq", seq[i], RR ? (i % 2) : 0);
      req_0 = 0; req_1 = 0;
      cyc();
      // write from port 1 then read back on port 0
      req_1 = 1; we_1 = 1; addr_1 = 32'h20; wdata_1 = 32'h12345678;
      cyc();
      req_1 = 0; we_1 = 0; req_0 = 1; addr_0 = 32'h20;
      cyc();
      req_0 = 0;
      chk("r032_rvalid_0", rvalid_0, 1'b1);
      chk("r032_rvalid_1", rvalid_1, 1'b0);
      chk("r032_rdata", rdata, 32'h12345678);
      cyc();
      // read pending when reset is asserted
      req_0 = 1; addr_0 = 32'h3;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0; req_0 = 0;
      cyc();
      // back-to-back alternating reads
      for (int i = 0; i < 8; i++) begin
         req_0 = (i % 2 == 0); req_1 = (i % 2 == 1);
         addr_0 = i; addr_1 = i;
         cyc();
      end
      req_0 = 0; req_1 = 0;
      cyc();
      // randomized traffic; an ungranted request is held unchanged
      act_0 = 0; act_1 = 0;
      for (int n = 0; n < 500; n++) begin
         if (!act_0 && $urandom_range(0, 2) != 0) begin
            act_0 = 1; we_0 = ($urandom_range(0, 3) == 0);
            addr_0 = $urandom_range(0, 255); wdata_0 = $urandom;
         end
         if (!act_1 && $urandom_range(0, 2) != 0) begin
            act_1 = 1; we_1 = ($urandom_range(0, 3) == 0);
            addr_1 = $urandom_range(0, 255); wdata_1 = $urandom;
         end
         req_0 = act_0; req_1 = act_1;
         rst = ($urandom_range(0, 59) == 0);
         cyc();
         if (last_win == 0) act_0 = 0;
         if (last_win == 1) act_1 = 0;
      end
      rst = 1'b0; req_0 = 0; req_1 = 0;
      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
